// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
// Shared definitions for the instruction fetch unit and the downstream decoder:
// fetch FSM state encoding, instruction geometry and the CBUS field positions.
// No ports (package).
package instruction_fetch_pkg;

  // Instruction geometry: three bytes, opcode byte first.
  localparam int unsigned INSTR_W     = 24;
  localparam int unsigned INSTR_BYTES = 3;

  // CBUS field positions, shared with the decoder.
  localparam int unsigned OPCODE_MSB = 23;
  localparam int unsigned OPCODE_LSB = 16;
  localparam int unsigned GROUP_MSB  = 23;
  localparam int unsigned GROUP_LSB  = 21;
  localparam int unsigned ARGS_MSB   = 15;
  localparam int unsigned ARGS_LSB   = 0;

  // Byte lanes of CBUS filled by the second and third reads.
  localparam int unsigned BYTE1_MSB = 15;
  localparam int unsigned BYTE1_LSB = 8;
  localparam int unsigned BYTE2_MSB = 7;
  localparam int unsigned BYTE2_LSB = 0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch0 = 3'd1,
    StFetch1 = 3'd2,
    StFetch2 = 3'd3,
    StHold   = 3'd4
  } fetch_state_e;

  // Offset of the byte being read relative to the instruction base address.
  function automatic logic [1:0] byte_offset(fetch_state_e st);
    logic [1:0] off;
    off = 2'd0;
    case (st)
      StFetch1: off = 2'd1;
      StFetch2: off = 2'd2;
      default:  off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/instruction_fetch_pc.sv
// instruction_fetch_pc
// Holds the base address of the instruction currently being fetched.
// Ports:
//   CLK        clock, state updates on posedge
//   RST        synchronous active-high reset, loads RESET_PC
//   load_i     redirect: take target_i (wins over incr_i)
//   target_i   redirect address
//   incr_i     advance to the next sequential instruction (+3, wrapping)
//   fetch_pc_o current fetch base address
module instruction_fetch_pc
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] fetch_pc_o
);

  logic [ADDR_W-1:0] fetch_pc_q;

  // Addition is at ADDR_W bits, so it wraps modulo 2^ADDR_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
    end else if (load_i) begin
      fetch_pc_q <= target_i;
    end else if (incr_i) begin
      fetch_pc_q <= fetch_pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  assign fetch_pc_o = fetch_pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Reads 24-bit instructions as three byte reads from an 8-bit memory bus and
// presents them to the decoder on CBUS with a valid/ack handshake. PC_LOAD
// redirects fetch at any time.
// Ports:
//   CLK, RST               clock and synchronous active-high reset
//   MEM_ADDR, MEM_RD       byte read request (address valid while MEM_RD)
//   MEM_RDY, MEM_DATA      read completion and data
//   CBUS, CBUS_VALID       assembled instruction and its qualifier
//   CBUS_ACK               decoder consumes CBUS
//   PC_LOAD, PC_TARGET     fetch redirect
//   PC                     address of the instruction on CBUS
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic               MEM_RD,
  input  logic               MEM_RDY,
  input  logic [7:0]         MEM_DATA,
  output logic [INSTR_W-1:0] CBUS,
  output logic               CBUS_VALID,
  input  logic               CBUS_ACK,
  input  logic               PC_LOAD,
  input  logic [ADDR_W-1:0]  PC_TARGET,
  output logic [ADDR_W-1:0]  PC
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] cbus_q, cbus_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               pc_incr;

  instruction_fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .CLK        (CLK),
    .RST        (RST),
    .load_i     (PC_LOAD),
    .target_i   (PC_TARGET),
    .incr_i     (pc_incr),
    .fetch_pc_o (fetch_pc)
  );

  always_comb begin
    state_d = state_q;
    cbus_d  = cbus_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    pc_incr = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch0;
      StFetch0: begin
        if (MEM_RDY) begin
          cbus_d[OPCODE_MSB:OPCODE_LSB] = MEM_DATA;
          state_d                       = StFetch1;
        end
      end
      StFetch1: begin
        if (MEM_RDY) begin
          cbus_d[BYTE1_MSB:BYTE1_LSB] = MEM_DATA;
          state_d                     = StFetch2;
        end
      end
      StFetch2: begin
        if (MEM_RDY) begin
          cbus_d[BYTE2_MSB:BYTE2_LSB] = MEM_DATA;
          state_d                     = StHold;
          valid_d                     = 1'b1;
          pc_d                        = fetch_pc;
        end
      end
      StHold: begin
        if (CBUS_ACK) begin
          valid_d = 1'b0;
          pc_incr = 1'b1;
          state_d = StFetch0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect discards any byte captured this cycle; an ack in HOLD is still
    // honoured (valid drops) but the fetch base comes from PC_TARGET.
    if (PC_LOAD) begin
      state_d = StFetch0;
      valid_d = 1'b0;
      cbus_d  = cbus_q;
      pc_d    = pc_q;
      pc_incr = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cbus_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      cbus_q  <= cbus_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  assign MEM_RD     = (state_q == StFetch0) || (state_q == StFetch1) ||
                      (state_q == StFetch2);
  assign MEM_ADDR   = fetch_pc + ADDR_W'(byte_offset(state_q));
  assign CBUS       = cbus_q;
  assign CBUS_VALID = valid_q;
  assign PC         = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] MEM_ADDR;
  logic        MEM_RD;
  logic        MEM_RDY;
  logic [7:0]  MEM_DATA;
  logic [23:0] CBUS;
  logic        CBUS_VALID;
  logic        CBUS_ACK;
  logic        PC_LOAD;
  logic [15:0] PC_TARGET;
  logic [15:0] PC;

  // Second instance: RESET_PC near the top of memory, always ready/acking.
  logic [15:0] w_addr;
  logic        w_rd;
  logic [7:0]  w_data;
  logic [23:0] w_cbus;
  logic        w_valid;
  logic [15:0] w_pc;

  logic [7:0] mem [0:65535];

  int tests = 0;
  int fails = 0;
  int wait_n = 0;
  int rdy_mode = 0;
  int wcnt = 0;

  assign MEM_DATA = mem[MEM_ADDR];
  assign w_data   = mem[w_addr];

  always #5 CLK = ~CLK;

  instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_RD     (MEM_RD),
    .MEM_RDY    (MEM_RDY),
    .MEM_DATA   (MEM_DATA),
    .CBUS       (CBUS),
    .CBUS_VALID (CBUS_VALID),
    .CBUS_ACK   (CBUS_ACK),
    .PC_LOAD    (PC_LOAD),
    .PC_TARGET  (PC_TARGET),
    .PC         (PC)
  );

  instruction_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFE)) dut_wrap (
    .CLK        (CLK),
    .RST        (RST),
    .MEM_ADDR   (w_addr),
    .MEM_RD     (w_rd),
    .MEM_RDY    (1'b1),
    .MEM_DATA   (w_data),
    .CBUS       (w_cbus),
    .CBUS_VALID (w_valid),
    .CBUS_ACK   (1'b1),
    .PC_LOAD    (1'b0),
    .PC_TARGET  (16'h0000),
    .PC         (w_pc)
  );

  // Memory responder: fixed wait count per read, or random ready every cycle.
  always @(negedge CLK) begin
    if (RST) begin
      wcnt    = 0;
      MEM_RDY = 1'b0;
    end else if (rdy_mode == 1) begin
      MEM_RDY = 1'($urandom_range(0, 1));
    end else if (MEM_RD) begin
      if (wcnt < wait_n) begin
        MEM_RDY = 1'b0;
        wcnt++;
      end else begin
        MEM_RDY = 1'b1;
        wcnt    = 0;
      end
    end else begin
      MEM_RDY = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] instr_at(input logic [15:0] a);
    logic [15:0] a1, a2;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    return {mem[a], mem[a1], mem[a2]};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_rd"},    32'(MEM_RD),     0);
    check({tag, "_addr"},  32'(MEM_ADDR),   0);
    check({tag, "_cbus"},  32'(CBUS),       0);
    check({tag, "_valid"}, 32'(CBUS_VALID), 0);
    check({tag, "_pc"},    32'(PC),         0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ea;
    logic [15:0] exp_pc;
    logic [15:0] load_tgt;
    logic        load_pend;
    logic        ack;
    logic        ld;
    logic [15:0] tgt;
    int          delivered;

    RST       = 1'b1;
    CBUS_ACK  = 1'b0;
    PC_LOAD   = 1'b0;
    PC_TARGET = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0000] = 8'h20; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h34;
    mem[16'h0003] = 8'h01; mem[16'h0004] = 8'hAB; mem[16'h0005] = 8'hCD;
    mem[16'h0100] = 8'h55; mem[16'h0101] = 8'h66; mem[16'h0102] = 8'h77;
    mem[16'h0200] = 8'h9A; mem[16'h0201] = 8'hBC; mem[16'h0202] = 8'hDE;

    // Reset values, then straight-line fetch with ready and ack high.
    tick();
    tick();
    check_reset("reset");
    check("wrap_reset_addr", 32'(w_addr), 32'hFFFE);
    check("wrap_reset_pc",   32'(w_pc),   32'hFFFE);
    RST      = 1'b0;
    CBUS_ACK = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 4 || n == 8) begin
        check("line_valid", 32'(CBUS_VALID), 1);
        check("line_rd",    32'(MEM_RD),     0);
        check("line_cbus",  32'(CBUS), (n == 4) ? 32'h201234 : 32'h01ABCD);
        check("line_pc",    32'(PC),   (n == 4) ? 32'h0000   : 32'h0003);
      end else begin
        check("line_valid0", 32'(CBUS_VALID), 0);
        check("line_rd1",    32'(MEM_RD),     1);
        check("line_addr",   32'(MEM_ADDR),   (n < 4) ? n - 1 : n - 2);
      end
      if (n <= 3) begin
        ea = 16'hFFFE + 16'(n - 1);
        check("wrap_addr", 32'(w_addr), 32'(ea));
        check("wrap_rd",   32'(w_rd),   1);
      end else if (n == 4) begin
        check("wrap_valid", 32'(w_valid), 1);
        check("wrap_pc",    32'(w_pc),    32'hFFFE);
        check("wrap_cbus",  32'(w_cbus),
              32'({mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000]}));
      end else if (n == 5) begin
        check("wrap_next_addr", 32'(w_addr), 32'h0001);
      end
    end

    // Wait states: two idle cycles before each byte.
    RST      = 1'b1;
    CBUS_ACK = 1'b0;
    wait_n   = 2;
    tick();
    RST = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      check("wait_rd",    32'(MEM_RD),     1);
      check("wait_addr",  32'(MEM_ADDR),   (n - 1) / 3);
      check("wait_valid", 32'(CBUS_VALID), 0);
    end
    tick();
    check("wait_valid1", 32'(CBUS_VALID), 1);
    check("wait_cbus",   32'(CBUS),       32'h201234);
    check("wait_pc",     32'(PC),         0);

    // Backpressure: hold for five cycles without ack.
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      check("hold_valid", 32'(CBUS_VALID), 1);
      check("hold_cbus",  32'(CBUS),       32'h201234);
      check("hold_pc",    32'(PC),         0);
      check("hold_rd",    32'(MEM_RD),     0);
    end
    CBUS_ACK = 1'b1;
    wait_n   = 0;
    tick();
    CBUS_ACK = 1'b0;
    check("ack_rd",    32'(MEM_RD),     1);
    check("ack_addr",  32'(MEM_ADDR),   3);
    check("ack_valid", 32'(CBUS_VALID), 0);

    // Redirect during the second byte read.
    tick();
    check("f1_addr", 32'(MEM_ADDR), 4);
    PC_LOAD   = 1'b1;
    PC_TARGET = 16'h0100;
    tick();
    PC_LOAD = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) tick();
      check("redir_addr",  32'(MEM_ADDR),   32'h0100 + n);
      check("redir_rd",    32'(MEM_RD),     1);
      check("redir_valid", 32'(CBUS_VALID), 0);
    end
    tick();
    check("redir_valid1", 32'(CBUS_VALID), 1);
    check("redir_cbus",   32'(CBUS),       32'h556677);
    check("redir_pc",     32'(PC),         32'h0100);

    // Load and ack together in HOLD.
    CBUS_ACK  = 1'b1;
    PC_LOAD   = 1'b1;
    PC_TARGET = 16'h0200;
    tick();
    CBUS_ACK = 1'b0;
    PC_LOAD  = 1'b0;
    check("both_valid", 32'(CBUS_VALID), 0);
    check("both_rd",    32'(MEM_RD),     1);
    check("both_addr",  32'(MEM_ADDR),   32'h0200);
    tick();
    check("both_valid_b", 32'(CBUS_VALID), 0);
    tick();
    check("both_valid_c", 32'(CBUS_VALID), 0);
    tick();
    check("both_valid1", 32'(CBUS_VALID), 1);
    check("both_cbus",   32'(CBUS),       32'h9ABCDE);
    check("both_pc",     32'(PC),         32'h0200);

    // Reset while reading the third byte.
    CBUS_ACK = 1'b1;
    tick();
    CBUS_ACK = 1'b0;
    check("next_addr", 32'(MEM_ADDR), 32'h0203);
    tick();
    tick();
    check("f2_addr", 32'(MEM_ADDR), 32'h0205);
    RST = 1'b1;
    tick();
    check_reset("rst_f2");
    tick();
    check("rst_hold_rd", 32'(MEM_RD), 0);
    RST = 1'b0;

    // Random ready, ack and redirects against an instruction-stream model.
    rdy_mode  = 1;
    exp_pc    = 16'h0000;
    load_pend = 1'b0;
    load_tgt  = 16'h0000;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (load_pend) begin
        check("rnd_load_rd",   32'(MEM_RD),   1);
        check("rnd_load_addr", 32'(MEM_ADDR), 32'(load_tgt));
        load_pend = 1'b0;
      end
      if (CBUS_VALID) begin
        check("rnd_cbus", 32'(CBUS),   32'(instr_at(exp_pc)));
        check("rnd_pc",   32'(PC),     32'(exp_pc));
        check("rnd_rd",   32'(MEM_RD), 0);
      end
      ack = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 31) == 0);
      tgt = 16'($urandom);
      CBUS_ACK  = ack;
      PC_LOAD   = ld;
      PC_TARGET = tgt;
      if (CBUS_VALID && ack) delivered++;
      if (ld) begin
        exp_pc    = tgt;
        load_pend = 1'b1;
        load_tgt  = tgt;
      end else if (CBUS_VALID && ack) begin
        exp_pc = exp_pc + 16'd3;
      end
      tick();
    end
    CBUS_ACK = 1'b0;
    PC_LOAD  = 1'b0;
    check("rnd_progress", 32'(delivered >= 50), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetches 24-bit instructions from the 8-bit memory bus and delivers them on CBUS to the downstream instruction decoder. Each instruction is three bytes, most significant (opcode) byte first. The block owns the fetch program counter. It performs three byte reads with a ready handshake, then holds the assembled word with a valid/ack handshake. A jump/branch can redirect it at any time via PC_LOAD.

## Interface
Parameters:
- ADDR_W, 16, memory address width.
- RESET_PC, 16'h0000, address of the first instruction after reset.

Ports:
- CLK  in  1  CPU clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- MEM_ADDR  out  ADDR_W  byte address of the current read.
- MEM_RD  out  1  read request.
- MEM_RDY  in  1  memory has MEM_DATA valid this cycle.
- MEM_DATA  in  8  read data.
- CBUS  out  24  assembled instruction: [23:16] opcode, [15:0] arguments.
- CBUS_VALID  out  1  CBUS holds a complete instruction.
- CBUS_ACK  in  1  decoder consumes CBUS this cycle.
- PC_LOAD  in  1  redirect fetch to PC_TARGET.
- PC_TARGET  in  ADDR_W  new instruction address.
- PC  out  ADDR_W  address of the instruction on CBUS (first byte).

## Operation
- States: IDLE, FETCH0, FETCH1, FETCH2, HOLD.
- Internal counters:
  - FETCH_PC: base address of the instruction being fetched.
  - Byte address: FETCH_PC + 0/1/2 in FETCH0/1/2. All address arithmetic is modulo 2^ADDR_W, so 16'hFFFF + 1 = 16'h0000.
- IDLE → FETCH0 unconditionally.
- FETCHn:
  - MEM_RD = 1 and MEM_ADDR = FETCH_PC + n, both held stable until MEM_RDY.
  - On a cycle with MEM_RDY = 1, MEM_DATA is captured into CBUS byte n (n=0 → [23:16], 1 → [15:8], 2 → [7:0]) and the state advances.
  - From FETCH2, on MEM_RDY: go to HOLD, set CBUS_VALID = 1, set PC = FETCH_PC.
- HOLD:
  - MEM_RD = 0; CBUS, PC and CBUS_VALID stay stable.
  - On CBUS_ACK: CBUS_VALID = 0, FETCH_PC += 3, next state FETCH0.
- PC_LOAD has the highest priority after RST and applies in any state:
  - next state is FETCH0, FETCH_PC = PC_TARGET, CBUS_VALID = 0;
  - any partially fetched bytes are discarded;
  - an outstanding MEM_RDY in the same cycle is ignored.
- PC_LOAD and CBUS_ACK in the same cycle: the ack is honoured (the decoder takes the current CBUS), and PC_TARGET, not FETCH_PC + 3, is the next fetch address.
- CBUS_ACK while CBUS_VALID = 0 is ignored.
- MEM_RDY while MEM_RD = 0 is ignored.
- CBUS bytes not yet refilled keep their old values; only CBUS_VALID qualifies CBUS.

## Timing
- Reset values (the cycle after RST is sampled high):
  - state IDLE; MEM_RD = 0; MEM_ADDR = RESET_PC;
  - CBUS = 24'h000000; CBUS_VALID = 0;
  - FETCH_PC = RESET_PC; PC = RESET_PC.
- RST mid-fetch or in HOLD aborts everything; outputs take reset values on the next edge.
- MEM_RD is decoded from state. It is 0 in IDLE and HOLD, so it is never asserted while RST is held.
- MEM_ADDR is valid in the same cycle MEM_RD is high.
- Latency with MEM_RDY tied high:
  - RST low at edge 0 → FETCH0 at cycle 1 → bytes captured at edges 2, 3, 4 → CBUS_VALID = 1 in cycle 4.
- Throughput: with ACK tied high, 4 cycles per instruction (3 reads + 1 HOLD). Every memory wait cycle adds 1.
- PC_LOAD asserted in cycle t: MEM_ADDR = PC_TARGET with MEM_RD = 1 in cycle t+1.

## Structure
- Shared header `fetch_defs.v` holds:
  - state encodings (3-bit localparams S_IDLE..S_HOLD);
  - INSTR_W = 24 and INSTR_BYTES = 3;
  - the CBUS field positions (opcode [23:16], group [23:21], args [15:0]), so the decoder uses the same constants.
- One natural sub-module, `fetch_pc`, holds the FETCH_PC register: load/increment-by-3 logic with wrap.
- The FSM and CBUS assembly stay in `instruction_fetch`.

## Test plan
- Reset, straight-line fetch: memory at 0x0000..0x0005 = 20 12 34 01 AB CD, MEM_RDY and ACK high → CBUS = 24'h201234 with PC = 0x0000, then CBUS = 24'h01ABCD with PC = 0x0003, 4 cycles apart.
- Wait states: MEM_RDY low for 2 cycles on each byte → MEM_ADDR stable during the waits; CBUS_VALID arrives 6 cycles later than the no-wait case; CBUS is still correct.
- Backpressure: ACK held low 5 cycles in HOLD → CBUS, PC and CBUS_VALID constant; MEM_RD = 0 throughout; the next fetch starts the cycle after ACK.
- Redirect mid-fetch: PC_LOAD with target 0x0100 during FETCH1 → next cycle MEM_ADDR = 0x0100, byte 0; the old partial instruction is never presented.
- Simultaneous PC_LOAD + ACK in HOLD → the current instruction is consumed once; the next fetch starts at PC_TARGET.
- Wrap and reset: RESET_PC = 16'hFFFE → bytes are read from FFFE, FFFF, 0000 and the next instruction starts at 0x0001. RST asserted in FETCH2 → all outputs take reset values.
